mux_n_reg: RTL and testbench
============================

Name: mux_n_reg

Overview:
- Parametrised N-input, WIDTH-bit datapath selector with registered output; next generation of the fixed 4:1 32-bit ALU-operand muxes.
- Adds load-enable hold, one-cycle result strobe, out-of-range select detection (sticky flag plus saturating error counter) and registered select echo.
- Sits between register-file/immediate sources and the ALU operand latches in the multicycle datapath; driven by control-unit select and load signals.

Parameters:
- WIDTH, 32, data width of each input and of out.
- N_IN, 4, number of inputs; legal range 2..16.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_IN.
- RESET_VAL, 0, value loaded into out on reset.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- in_bus  input  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input index.
- load  input  1  capture enable.
- clr_err  input  1  synchronous clear of err_sticky and err_cnt.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  one-cycle strobe: out updated this cycle.
- sel_q  output  SEL_W  index of the last successfully loaded input.
- err_pulse  output  1  one-cycle strobe: last load had an illegal select.
- err_sticky  output  1  set on any illegal select; held until clr_err.
- err_cnt  output  ERR_CNT_W  count of illegal selects, saturating at all-ones.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately regardless of clk):
  - out=RESET_VAL, sel_q=0.
  - out_valid=0, err_pulse=0, err_sticky=0, err_cnt=0.
  - Reset mid-operation aborts any pending load; first capture can occur on the first rising edge after reset returns to 1.
- Latency: exactly 1 cycle. in_bus and sel are sampled at the rising edge where load=1; out changes on that edge.
- Legal load (load=1, sel<N_IN), at the edge:
  - out <= input[sel], sel_q <= sel.
  - out_valid <= 1, err_pulse <= 0.
- Illegal load (load=1, sel>=N_IN):
  - out and sel_q hold their previous values; X is never driven.
  - out_valid <= 0, err_pulse <= 1, err_sticky <= 1.
  - err_cnt increments unless already all-ones.
- No load (load=0):
  - out and sel_q hold.
  - out_valid <= 0, err_pulse <= 0.
- Back-to-back loads on consecutive cycles are each captured; out_valid stays high across consecutive legal loads.
- clr_err=1 at an edge: err_sticky <= 0, err_cnt <= 0.
  - Simultaneous clr_err and illegal load: the error wins, giving err_sticky=1 and err_cnt=1.
  - clr_err has no effect on out, sel_q, out_valid or err_pulse.
- Saturation: err_cnt stays at 2**ERR_CNT_W-1 on further errors; no wrap to 0.
- When N_IN equals 2**SEL_W, an illegal select cannot occur and the error logic is constant 0.
- in_bus changes without load=1 never affect out; the block is not transparent.
- Combinational path from sel/in_bus to out is prohibited; all outputs are registered.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, keep load=0 for 3 cycles -> out=0, out_valid=0, sel_q=0, err_sticky=0, err_cnt=0 throughout.
- Legal sweep (N_IN=4, WIDTH=32):
  - Stimulus: inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444; load=1 with sel=0,1,2,3 on consecutive cycles.
  - Required: out = 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle after each sel, out_valid=1 on all four cycles, sel_q tracks sel.
- Hold:
  - Stimulus: load sel=2; then change in_bus input 2 to 0xDEADBEEF with load=0 for 3 cycles.
  - Required: out stays 0x33333333, out_valid=0 after the first cycle.
- Illegal select (N_IN=5, SEL_W=3):
  - Stimulus: load sel=1 (input 0xA5A5A5A5), then load sel=6.
  - Required: out stays 0xA5A5A5A5, sel_q=1, err_pulse=1 for one cycle, out_valid=0, err_sticky=1, err_cnt=1.
- Clear/error collision and saturation (ERR_CNT_W=2):
  - Stimulus: 5 illegal loads.
  - Required: err_cnt = 1, 2, 3, 3, 3.
  - Stimulus: clr_err with load=0.
  - Required: err_cnt=0, err_sticky=0.
  - Stimulus: clr_err together with an illegal load.
  - Required: err_sticky=1, err_cnt=1.
- Asynchronous reset mid-stream:
  - Stimulus: out=0x44444444; drive reset=0 between clock edges.
  - Required: out=RESET_VAL and all flags 0 before the next rising edge; a load asserted during reset is ignored.

Source files
------------

// File: rtl/mux_n_reg.sv
// Parametrised N-input, WIDTH-bit operand selector with a registered output, load-enable hold,
// a result strobe, a registered select echo and out-of-range select detection with a sticky flag.
module mux_n_reg #(
    parameter int                 WIDTH     = 32,
    parameter int                 N_IN      = 4,
    parameter int                 SEL_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      sel_q,
    output logic                  err_pulse,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    // One extra bit so N_IN == 2**SEL_W is representable; then the compare is constant-true
    // and the whole error path folds to constant 0.
    localparam logic [SEL_W:0] N_IN_L = (SEL_W+1)'(N_IN);

    logic                 w_sel_legal;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic                 w_cnt_max;
    logic [WIDTH-1:0]     w_sel_data;

    logic [WIDTH-1:0]     r_out;
    logic                 r_out_valid;
    logic [SEL_W-1:0]     r_sel_q;
    logic                 r_err_pulse;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_sel_legal = ({1'b0, sel} < N_IN_L);
    assign w_load_ok   = load & w_sel_legal;
    assign w_load_bad  = load & ~w_sel_legal;
    assign w_cnt_max   = &r_err_cnt;

    // NOTE: the default before the loop keeps this purely combinational; without it an
    // unmatched select would have to hold the old value and a latch would be inferred.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out       <= RESET_VAL;
            r_sel_q     <= '0;
            r_out_valid <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_out_valid <= w_load_ok;
            r_err_pulse <= w_load_bad;
            if (w_load_ok) begin
                r_out   <= w_sel_data;
                r_sel_q <= sel;
            end
        end
    end

    // An illegal load in the same cycle as clr_err wins: the clear is applied first,
    // so the counter restarts at 1 instead of being zeroed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_load_bad) begin
            r_err_sticky <= 1'b1;
            if (clr_err) begin
                r_err_cnt <= ERR_CNT_W'(1);
            end else if (!w_cnt_max) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end
    end

    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign sel_q      = r_sel_q;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: a 5-input instance with a 2-bit error counter (illegal selects possible)
// and a 4-input instance with a 2-bit select (illegal selects impossible).
module tb_mux_n_reg;

    localparam int WIDTH   = 32;
    localparam int N_IN    = 5;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [N_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]      sel = '0;
    logic                  load = 1'b0;
    logic                  clr_err = 1'b0;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic [SEL_W-1:0]      sel_q;
    logic                  err_pulse;
    logic                  err_sticky;
    logic [CNT_W-1:0]      err_cnt;

    logic [WIDTH-1:0]      in_word [N_IN];

    logic [4*WIDTH-1:0]    f_in_bus;
    logic [1:0]            f_sel = '0;
    logic                  f_load = 1'b0;
    logic [WIDTH-1:0]      f_out;
    logic                  f_valid;
    logic [1:0]            f_sel_q;
    logic                  f_pulse;
    logic                  f_sticky;
    logic [7:0]            f_cnt;
    logic [WIDTH-1:0]      f_word [4];

    int checks = 0;
    int errors = 0;

    // Reference model state, updated once per applied cycle
    logic [WIDTH-1:0] m_out;
    int               m_sel_q;
    bit               m_valid, m_pulse, m_sticky;
    int               m_cnt;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N_IN; k++) in_bus[k*WIDTH +: WIDTH] = in_word[k];
        for (int k = 0; k < 4; k++) f_in_bus[k*WIDTH +: WIDTH] = f_word[k];
    end

    mux_n_reg #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .RESET_VAL('0), .ERR_CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .load(load), .clr_err(clr_err),
        .out(out), .out_valid(out_valid), .sel_q(sel_q), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    mux_n_reg #(.WIDTH(WIDTH), .N_IN(4), .SEL_W(2), .RESET_VAL('0), .ERR_CNT_W(8)) dut_full (
        .clk(clk), .reset(reset), .in_bus(f_in_bus), .sel(f_sel), .load(f_load), .clr_err(1'b0),
        .out(f_out), .out_valid(f_valid), .sel_q(f_sel_q), .err_pulse(f_pulse),
        .err_sticky(f_sticky), .err_cnt(f_cnt)
    );

    task automatic model_reset();
        m_out = '0; m_sel_q = 0; m_valid = 0; m_pulse = 0; m_sticky = 0; m_cnt = 0;
    endtask

    // Drive one cycle at the falling edge, advance the model, then return 1 ns after the rising edge.
    task automatic apply(input bit ld, input int s, input bit clr);
        bit bad;
        @(negedge clk);
        load = ld; sel = SEL_W'(s); clr_err = clr;
        bad = ld && (s >= N_IN);
        m_valid = ld && !bad;
        m_pulse = bad;
        if (ld && !bad) begin
            m_out   = in_word[s];
            m_sel_q = s;
        end
        if (clr) begin
            m_sticky = 0;
            m_cnt    = 0;
        end
        if (bad) begin
            m_sticky = 1;
            m_cnt    = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N_IN; k++) in_word[k] = '0;
        for (int k = 0; k < 4; k++) f_word[k] = '0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || sel_q !== '0 || err_pulse !== 1'b0 ||
            err_sticky !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_hold: out=%h valid=%b sel_q=%0d pulse=%b sticky=%b cnt=%0d, want all 0",
                     out, out_valid, sel_q, err_pulse, err_sticky, err_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0);
            checks++;
            if (out !== '0 || out_valid !== 1'b0 || sel_q !== '0 || err_sticky !== 1'b0 || err_cnt !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: out=%h valid=%b sel_q=%0d sticky=%b cnt=%0d, want all 0",
                         i, out, out_valid, sel_q, err_sticky, err_cnt);
            end
        end
    endtask

    task automatic test_legal_sweep();
        logic [WIDTH-1:0] exp_w [4];
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        for (int k = 0; k < 4; k++) in_word[k] = exp_w[k];
        in_word[4] = 32'h55555555;
        for (int k = 0; k < 4; k++) begin
            apply(1, k, 0);
            checks++;
            if (out !== exp_w[k] || out_valid !== 1'b1 || sel_q !== SEL_W'(k) || err_pulse !== 1'b0) begin
                errors++;
                $display("FAIL sweep[%0d]: out=%h valid=%b sel_q=%0d pulse=%b, want out=%h valid=1 sel_q=%0d pulse=0",
                         k, out, out_valid, sel_q, err_pulse, exp_w[k], k);
            end
        end
    endtask

    task automatic test_hold();
        apply(1, 2, 0);
        checks++;
        if (out !== 32'h33333333 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load: out=%h valid=%b, want 33333333 valid=1", out, out_valid);
        end
        in_word[2] = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            apply(0, 2, 0);
            checks++;
            if (out !== 32'h33333333 || out_valid !== 1'b0 || sel_q !== 3'd2) begin
                errors++;
                $display("FAIL hold[%0d]: out=%h valid=%b sel_q=%0d, want 33333333 valid=0 sel_q=2",
                         i, out, out_valid, sel_q);
            end
        end
    endtask

    task automatic test_illegal();
        in_word[1] = 32'hA5A5A5A5;
        apply(1, 1, 0);
        checks++;
        if (out !== 32'hA5A5A5A5 || sel_q !== 3'd1) begin
            errors++;
            $display("FAIL illegal_setup: out=%h sel_q=%0d, want a5a5a5a5 sel_q=1", out, sel_q);
        end
        apply(1, 6, 0);
        checks++;
        if (out !== 32'hA5A5A5A5 || sel_q !== 3'd1 || err_pulse !== 1'b1 || out_valid !== 1'b0 ||
            err_sticky !== 1'b1 || err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL illegal_sel: out=%h sel_q=%0d pulse=%b valid=%b sticky=%b cnt=%0d, want a5a5a5a5 1 1 0 1 1",
                     out, sel_q, err_pulse, out_valid, err_sticky, err_cnt);
        end
        apply(0, 0, 0);
        checks++;
        if (err_pulse !== 1'b0 || err_sticky !== 1'b1 || err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL illegal_after: pulse=%b sticky=%b cnt=%0d, want 0 1 1", err_pulse, err_sticky, err_cnt);
        end
    endtask

    task automatic test_saturation_clear();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        apply(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            apply(1, 5 + (i % 3), 0);
            checks++;
            if (err_cnt !== CNT_W'(exp_cnt[i]) || err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
                errors++;
                $display("FAIL saturate[%0d]: cnt=%0d sticky=%b pulse=%b, want %0d 1 1",
                         i, err_cnt, err_sticky, err_pulse, exp_cnt[i]);
            end
        end
        apply(0, 0, 1);
        checks++;
        if (err_cnt !== '0 || err_sticky !== 1'b0 || out !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL clear: cnt=%0d sticky=%b out=%h, want 0 0 a5a5a5a5", err_cnt, err_sticky, out);
        end
        apply(1, 7, 1);
        checks++;
        if (err_cnt !== 2'd1 || err_sticky !== 1'b1 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_collision: cnt=%0d sticky=%b pulse=%b, want 1 1 1", err_cnt, err_sticky, err_pulse);
        end
    endtask

    task automatic test_async_reset();
        in_word[3] = 32'h44444444;
        apply(1, 3, 0);
        checks++;
        if (out !== 32'h44444444) begin
            errors++;
            $display("FAIL areset_setup: out=%h, want 44444444", out);
        end
        #2;
        load = 1'b1; sel = 3'd0; reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || sel_q !== '0 || err_pulse !== 1'b0 ||
            err_sticky !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL areset_immediate: out=%h valid=%b sel_q=%0d pulse=%b sticky=%b cnt=%0d, want all 0",
                     out, out_valid, sel_q, err_pulse, err_sticky, err_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== '0 || out_valid !== 1'b0 || sel_q !== '0) begin
            errors++;
            $display("FAIL areset_load_ignored: out=%h valid=%b sel_q=%0d, want 0 0 0", out, out_valid, sel_q);
        end
        @(negedge clk);
        reset = 1'b1; load = 1'b0;
        in_word[2] = 32'h0BADF00D;
        apply(1, 2, 0);
        checks++;
        if (out !== 32'h0BADF00D || out_valid !== 1'b1 || sel_q !== 3'd2) begin
            errors++;
            $display("FAIL areset_first_load: out=%h valid=%b sel_q=%0d, want 0badf00d 1 2", out, out_valid, sel_q);
        end
    endtask

    // All four selects of a 2-bit select are legal, so the error outputs must never move.
    task automatic test_full_range();
        logic [WIDTH-1:0] fm_out = '0;
        int               fm_sel = 0;
        bit               fm_valid;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) f_word[k] = $urandom;
            f_load = 1'($urandom_range(0, 1));
            f_sel  = 2'($urandom_range(0, 3));
            fm_valid = f_load;
            if (f_load) begin
                fm_out = f_word[f_sel];
                fm_sel = f_sel;
            end
            @(posedge clk);
            #1;
            checks++;
            if (f_out !== fm_out || f_valid !== fm_valid || f_sel_q !== 2'(fm_sel) ||
                f_pulse !== 1'b0 || f_sticky !== 1'b0 || f_cnt !== '0) begin
                errors++;
                $display("FAIL full_range[%0d]: out=%h valid=%b sel_q=%0d pulse=%b sticky=%b cnt=%0d, want out=%h valid=%b sel_q=%0d errs 0",
                         i, f_out, f_valid, f_sel_q, f_pulse, f_sticky, f_cnt, fm_out, fm_valid, fm_sel);
            end
        end
        f_load = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N_IN; k++) in_word[k] = $urandom;
            apply(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
            checks++;
            if (out !== m_out || out_valid !== m_valid || sel_q !== SEL_W'(m_sel_q) || err_pulse !== m_pulse ||
                err_sticky !== m_sticky || err_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: out=%h valid=%b sel_q=%0d pulse=%b sticky=%b cnt=%0d, want %h %b %0d %b %b %0d",
                         i, out, out_valid, sel_q, err_pulse, err_sticky, err_cnt,
                         m_out, m_valid, m_sel_q, m_pulse, m_sticky, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal_sweep();
        test_hold();
        test_illegal();
        test_saturation_clear();
        test_async_reset();
        test_full_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
